// File: rtl/gemm_sched_pkg.sv
// Shared types for the GeMM job scheduler: FSM state encoding, default
// widths and the job payload struct (m/k/n sizes at the default width).
package gemm_sched_pkg;

    localparam int unsigned DefNumReq     = 4;
    localparam int unsigned DefAddrWidth  = 16;
    localparam int unsigned DefCycleWidth = 32;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLaunch  = 2'd1,
        StWait    = 2'd2,
        StRespond = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [DefAddrWidth-1:0] m_size;
        logic [DefAddrWidth-1:0] k_size;
        logic [DefAddrWidth-1:0] n_size;
    } gemm_job_t;

endpackage

// File: rtl/gemm_job_scheduler_if.sv
// Requester-side job/completion handshake bundle.
//   master: requesters (drive req_valid/sizes, rsp_ready)
//   slave : scheduler  (drives req_ready, rsp_valid/err/cycles)
interface gemm_job_scheduler_if #(
    parameter int unsigned NumReq     = 4,
    parameter int unsigned AddrWidth  = 16,
    parameter int unsigned CycleWidth = 32
);
    logic [NumReq-1:0]                req_valid;
    logic [NumReq-1:0]                req_ready;
    logic [NumReq-1:0][AddrWidth-1:0] req_m_size;
    logic [NumReq-1:0][AddrWidth-1:0] req_k_size;
    logic [NumReq-1:0][AddrWidth-1:0] req_n_size;
    logic [NumReq-1:0]                rsp_valid;
    logic [NumReq-1:0]                rsp_ready;
    logic                             rsp_err;
    logic [CycleWidth-1:0]            rsp_cycles;

    modport master (
        output req_valid, req_m_size, req_k_size, req_n_size, rsp_ready,
        input  req_ready, rsp_valid, rsp_err, rsp_cycles
    );

    modport slave (
        input  req_valid, req_m_size, req_k_size, req_n_size, rsp_ready,
        output req_ready, rsp_valid, rsp_err, rsp_cycles
    );
endinterface

// File: rtl/gemm_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at rr_ptr_i and
// wraps; at most one grant bit is set, and only when en_i is high.
//   req_i     : request vector
//   rr_ptr_i  : highest-priority index
//   en_i      : arbitration enable
//   gnt_o     : one-hot grant
//   gnt_idx_o : index of the granted requester
//   gnt_any_o : a grant was issued
module gemm_rr_arbiter #(
    parameter  int unsigned NumReq   = 4,
    localparam int unsigned IdxWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]   req_i,
    input  logic [IdxWidth-1:0] rr_ptr_i,
    input  logic                en_i,
    output logic [NumReq-1:0]   gnt_o,
    output logic [IdxWidth-1:0] gnt_idx_o,
    output logic                gnt_any_o
);

    // First requester found walking from rr_ptr_i wins.
    always_comb begin
        logic [IdxWidth-1:0] idx;
        idx       = '0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = IdxWidth'((32'(rr_ptr_i) + i) % NumReq);
            if (en_i && !gnt_any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
                gnt_any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gemm_job_scheduler.sv
// Shares one GeMM engine between NumReq requesters: round-robin grant in
// Idle, latch sizes, pulse start_o, wait for done_i, then hold the
// completion (error flag + cycle count) until the owner consumes it.
//   clk_i, rst_ni          : clock, async active-low reset
//   req_if                 : requester job/completion handshakes
//   start_o                : one-cycle engine start pulse
//   m/k/n_size_o           : latched job sizes to the engine
//   done_i                 : engine completion pulse
//   busy_o                 : scheduler not idle
//   owner_o                : requester currently owning the engine
module gemm_job_scheduler
    import gemm_sched_pkg::*;
#(
    parameter  int unsigned NumReq     = DefNumReq,
    parameter  int unsigned AddrWidth  = DefAddrWidth,
    parameter  int unsigned CycleWidth = DefCycleWidth,
    localparam int unsigned IdxWidth   = $clog2(NumReq)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    gemm_job_scheduler_if.slave   req_if,
    output logic                  start_o,
    output logic [AddrWidth-1:0]  m_size_o,
    output logic [AddrWidth-1:0]  k_size_o,
    output logic [AddrWidth-1:0]  n_size_o,
    input  logic                  done_i,
    output logic                  busy_o,
    output logic [IdxWidth-1:0]   owner_o
);

    sched_state_t          state_q, state_d;
    logic [IdxWidth-1:0]   owner_q, owner_d;
    logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AddrWidth-1:0]  m_q, m_d, k_q, k_d, n_q, n_d;
    logic                  err_q, err_d;
    logic [CycleWidth-1:0] cycle_q, cycle_d;

    logic [NumReq-1:0]     gnt;
    logic [IdxWidth-1:0]   gnt_idx;
    logic                  gnt_any;
    logic [AddrWidth-1:0]  gnt_m, gnt_k, gnt_n;
    logic [CycleWidth-1:0] cycle_inc;

    gemm_rr_arbiter #(
        .NumReq (NumReq)
    ) u_arb (
        .req_i     (req_if.req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .en_i      (state_q == StIdle),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    assign gnt_m = req_if.req_m_size[gnt_idx];
    assign gnt_k = req_if.req_k_size[gnt_idx];
    assign gnt_n = req_if.req_n_size[gnt_idx];

    // Saturating increment of the job cycle counter.
    assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + CycleWidth'(1);

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        m_d      = m_q;
        k_d      = k_q;
        n_d      = n_q;
        err_d    = err_q;
        cycle_d  = cycle_q;
        case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    owner_d = gnt_idx;
                    m_d     = gnt_m;
                    k_d     = gnt_k;
                    n_d     = gnt_n;
                    cycle_d = '0;
                    // A zero-sized job is answered with an error and never launched.
                    err_d   = ~|gnt_m | ~|gnt_k | ~|gnt_n;
                    state_d = err_d ? StRespond : StLaunch;
                end
            end
            StLaunch: begin
                cycle_d = cycle_inc;
                state_d = StWait;
            end
            StWait: begin
                // The done cycle itself is not counted.
                if (done_i) begin
                    state_d = StRespond;
                end else begin
                    cycle_d = cycle_inc;
                end
            end
            StRespond: begin
                if (req_if.rsp_ready[owner_q]) begin
                    state_d  = StIdle;
                    rr_ptr_d = (owner_q == IdxWidth'(NumReq - 1)) ? '0
                                                                   : owner_q + IdxWidth'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            m_q      <= '0;
            k_q      <= '0;
            n_q      <= '0;
            err_q    <= 1'b0;
            cycle_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            m_q      <= m_d;
            k_q      <= k_d;
            n_q      <= n_d;
            err_q    <= err_d;
            cycle_q  <= cycle_d;
        end
    end

    assign req_if.req_ready  = gnt;
    assign req_if.rsp_valid  = (state_q == StRespond) ? (NumReq'(1) << owner_q) : '0;
    assign req_if.rsp_err    = err_q;
    assign req_if.rsp_cycles = cycle_q;
    assign start_o           = (state_q == StLaunch);
    assign busy_o            = (state_q != StIdle);
    assign owner_o           = owner_q;
    assign m_size_o          = m_q;
    assign k_size_o          = k_q;
    assign n_size_o          = n_q;

endmodule

// File: tb/tb_gemm_job_scheduler.sv
// Self-checking bench for gemm_job_scheduler: expected completions are
// queued at grant time and popped when rsp_valid_o appears.
module tb_gemm_job_scheduler;
    import gemm_sched_pkg::*;

    localparam int unsigned NumReq = 4;
    localparam int unsigned AddrW  = 16;
    localparam int unsigned CycW   = 32;
    localparam int unsigned IdxW   = 2;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             start_o;
    logic [AddrW-1:0] m_size_o, k_size_o, n_size_o;
    logic             done_i;
    logic             busy_o;
    logic [IdxW-1:0]  owner_o;

    gemm_job_scheduler_if #(.NumReq(NumReq), .AddrWidth(AddrW), .CycleWidth(CycW)) bus ();

    gemm_job_scheduler #(.NumReq(NumReq), .AddrWidth(AddrW), .CycleWidth(CycW)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_if   (bus),
        .start_o  (start_o),
        .m_size_o (m_size_o),
        .k_size_o (k_size_o),
        .n_size_o (n_size_o),
        .done_i   (done_i),
        .busy_o   (busy_o),
        .owner_o  (owner_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IdxW-1:0] owner;
        logic            err;
        logic [CycW-1:0] cycles;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic set_job(input logic [IdxW-1:0] r, input gemm_job_t j);
        bus.req_m_size[r] = j.m_size;
        bus.req_k_size[r] = j.k_size;
        bus.req_n_size[r] = j.n_size;
    endtask

    task automatic test_reset();
        rst_ni         = 1'b0;
        done_i         = 1'b0;
        bus.req_valid  = '0;
        bus.rsp_ready  = '0;
        bus.req_m_size = '0;
        bus.req_k_size = '0;
        bus.req_n_size = '0;
        repeat (2) @(posedge clk_i);
        sample();
        n_checks++;
        if ({start_o, busy_o} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ctrl start/busy got %b want 00", {start_o, busy_o});
        end
        n_checks++;
        if (owner_o !== '0) begin
            n_fail++; $display("FAIL reset_owner got %0d want 0", owner_o);
        end
        n_checks++;
        if ({m_size_o, k_size_o, n_size_o} !== '0) begin
            n_fail++; $display("FAIL reset_sizes got %h want 0", {m_size_o, k_size_o, n_size_o});
        end
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_cycles, bus.req_ready} !== '0) begin
            n_fail++; $display("FAIL reset_rsp valid=%b err=%b cyc=%0d ready=%b want all 0",
                               bus.rsp_valid, bus.rsp_err, bus.rsp_cycles, bus.req_ready);
        end
        cyc();
        rst_ni = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [IdxW-1:0]   exp_idx;
        logic [NumReq-1:0] exp_vec;
        for (int r = 0; r < 4; r++) begin
            set_job(IdxW'(r), '{m_size: AddrW'(r + 1), k_size: AddrW'(r + 2), n_size: AddrW'(r + 3)});
        end
        bus.rsp_ready = '1;
        bus.req_valid = '1;
        sample();
        for (int j = 0; j < 5; j++) begin
            exp_idx = IdxW'(j % 4);
            exp_vec = 4'b0001 << exp_idx;
            n_checks++;
            if (bus.req_ready !== exp_vec || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL rr_grant job %0d ready=%b busy=%b want %b busy=0",
                                   j, bus.req_ready, busy_o, exp_vec);
            end
            exp_q.push_back('{owner: exp_idx, err: 1'b0, cycles: CycW'(j + 1)});
            cyc();
            sample();
            n_checks++;
            if (start_o !== 1'b1 || busy_o !== 1'b1 || bus.req_ready !== '0 || owner_o !== exp_idx) begin
                n_fail++; $display("FAIL rr_launch job %0d start=%b busy=%b ready=%b owner=%0d want 1 1 0000 %0d",
                                   j, start_o, busy_o, bus.req_ready, owner_o, exp_idx);
            end
            for (int w = 0; w <= j; w++) cyc();
            done_i = 1'b1;
            cyc();
            done_i = 1'b0;
            if (j == 4) bus.req_valid = '0;
            sample();
            n_checks++;
            if (bus.rsp_valid !== exp_vec || busy_o !== 1'b1) begin
                n_fail++; $display("FAIL rr_rsp_valid job %0d got %b busy=%b want %b busy=1",
                                   j, bus.rsp_valid, busy_o, exp_vec);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL rr_scoreboard job %0d got empty queue want entry", j);
            end else begin
                e = exp_q.pop_front();
                if (bus.rsp_cycles !== e.cycles || bus.rsp_err !== e.err || owner_o !== e.owner) begin
                    n_fail++; $display("FAIL rr_rsp job %0d cyc=%0d err=%b owner=%0d want %0d %b %0d",
                                       j, bus.rsp_cycles, bus.rsp_err, owner_o, e.cycles, e.err, e.owner);
                end
            end
            cyc();
            sample();
        end
        n_checks++;
        if (busy_o !== 1'b0 || bus.req_ready !== '0) begin
            n_fail++; $display("FAIL rr_end busy=%b ready=%b want 0 0000", busy_o, bus.req_ready);
        end
        bus.rsp_ready = '0;
    endtask

    task automatic test_single();
        cyc();
        set_job(2'd0, '{m_size: 16'd2, k_size: 16'd3, n_size: 16'd4});
        bus.req_valid = 4'b0001;
        sample();
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_grant got %b want 0001", bus.req_ready);
        end
        exp_q.push_back('{owner: 2'd0, err: 1'b0, cycles: 32'd10});
        cyc();
        bus.req_valid = '0;
        sample();
        n_checks++;
        if (start_o !== 1'b1 || {m_size_o, k_size_o, n_size_o} !== {16'd2, 16'd3, 16'd4}) begin
            n_fail++; $display("FAIL single_start start=%b sizes=%0d/%0d/%0d want 1 2/3/4",
                               start_o, m_size_o, k_size_o, n_size_o);
        end
        for (int w = 0; w < 9; w++) begin
            cyc();
            sample();
            n_checks++;
            if (start_o !== 1'b0 || busy_o !== 1'b1) begin
                n_fail++; $display("FAIL single_wait w=%0d start=%b busy=%b want 0 1", w, start_o, busy_o);
            end
        end
        cyc();
        done_i = 1'b1;
        cyc();
        done_i = 1'b0;
        sample();
        n_checks++;
        if (bus.rsp_valid !== 4'b0001 || {m_size_o, k_size_o, n_size_o} !== {16'd2, 16'd3, 16'd4}) begin
            n_fail++; $display("FAIL single_rsp_valid got %b sizes=%0d/%0d/%0d want 0001 2/3/4",
                               bus.rsp_valid, m_size_o, k_size_o, n_size_o);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL single_scoreboard got empty queue want entry");
        end else begin
            e = exp_q.pop_front();
            if (bus.rsp_cycles !== e.cycles || bus.rsp_err !== e.err) begin
                n_fail++; $display("FAIL single_rsp cyc=%0d err=%b want %0d %b",
                                   bus.rsp_cycles, bus.rsp_err, e.cycles, e.err);
            end
        end
        bus.rsp_ready = 4'b0001;
        cyc();
        bus.rsp_ready = '0;
        sample();
        n_checks++;
        if (busy_o !== 1'b0 || bus.rsp_valid !== '0) begin
            n_fail++; $display("FAIL single_idle busy=%b rsp_valid=%b want 0 0000", busy_o, bus.rsp_valid);
        end
    endtask

    task automatic test_zero_size();
        cyc();
        set_job(2'd2, '{m_size: 16'd5, k_size: 16'd0, n_size: 16'd7});
        bus.req_valid = 4'b0100;
        sample();
        n_checks++;
        if (bus.req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL zero_grant got %b want 0100", bus.req_ready);
        end
        exp_q.push_back('{owner: 2'd2, err: 1'b1, cycles: 32'd0});
        cyc();
        bus.req_valid = '0;
        sample();
        n_checks++;
        if (start_o !== 1'b0 || bus.rsp_valid !== 4'b0100) begin
            n_fail++; $display("FAIL zero_rsp_valid start=%b rsp_valid=%b want 0 0100", start_o, bus.rsp_valid);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL zero_scoreboard got empty queue want entry");
        end else begin
            e = exp_q.pop_front();
            if (bus.rsp_cycles !== e.cycles || bus.rsp_err !== e.err || owner_o !== e.owner) begin
                n_fail++; $display("FAIL zero_rsp cyc=%0d err=%b owner=%0d want %0d %b %0d",
                                   bus.rsp_cycles, bus.rsp_err, owner_o, e.cycles, e.err, e.owner);
            end
        end
        bus.rsp_ready = 4'b0100;
        cyc();
        bus.rsp_ready = '0;
        sample();
        n_checks++;
        if (busy_o !== 1'b0 || start_o !== 1'b0) begin
            n_fail++; $display("FAIL zero_idle busy=%b start=%b want 0 0", busy_o, start_o);
        end
    endtask

    task automatic test_fast_done();
        cyc();
        set_job(2'd3, '{m_size: 16'd1, k_size: 16'd1, n_size: 16'd1});
        bus.req_valid = 4'b1000;
        sample();
        n_checks++;
        if (bus.req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL fast_grant got %b want 1000", bus.req_ready);
        end
        exp_q.push_back('{owner: 2'd3, err: 1'b0, cycles: 32'd1});
        cyc();
        bus.req_valid = '0;
        cyc();
        done_i = 1'b1;
        cyc();
        done_i = 1'b0;
        sample();
        n_checks++;
        if (bus.rsp_valid !== 4'b1000) begin
            n_fail++; $display("FAIL fast_rsp_valid got %b want 1000", bus.rsp_valid);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL fast_scoreboard got empty queue want entry");
        end else begin
            e = exp_q.pop_front();
            if (bus.rsp_cycles !== e.cycles || bus.rsp_err !== e.err) begin
                n_fail++; $display("FAIL fast_rsp cyc=%0d err=%b want %0d %b",
                                   bus.rsp_cycles, bus.rsp_err, e.cycles, e.err);
            end
        end
        bus.rsp_ready = 4'b0111;
        cyc();
        sample();
        n_checks++;
        if (bus.rsp_valid !== 4'b1000 || busy_o !== 1'b1 || bus.rsp_cycles !== 32'd1) begin
            n_fail++; $display("FAIL fast_wrong_owner rsp_valid=%b busy=%b cyc=%0d want 1000 1 1",
                               bus.rsp_valid, busy_o, bus.rsp_cycles);
        end
        bus.rsp_ready = 4'b1000;
        cyc();
        bus.rsp_ready = '0;
        sample();
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL fast_idle busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_backpressure();
        cyc();
        set_job(2'd1, '{m_size: 16'd8, k_size: 16'd9, n_size: 16'd10});
        bus.req_valid = 4'b0010;
        sample();
        n_checks++;
        if (bus.req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_grant got %b want 0010", bus.req_ready);
        end
        exp_q.push_back('{owner: 2'd1, err: 1'b0, cycles: 32'd3});
        cyc();
        bus.req_valid = '0;
        repeat (3) cyc();
        done_i = 1'b1;
        cyc();
        done_i = 1'b0;
        sample();
        n_checks++;
        if (exp_q.size() == 0 || bus.rsp_valid !== 4'b0010) begin
            n_fail++; $display("FAIL bp_rsp_valid got %b queue=%0d want 0010 nonempty",
                               bus.rsp_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (bus.rsp_cycles !== e.cycles || bus.rsp_err !== e.err) begin
                n_fail++; $display("FAIL bp_rsp cyc=%0d err=%b want %0d %b",
                                   bus.rsp_cycles, bus.rsp_err, e.cycles, e.err);
            end
        end
        for (int w = 0; w < 5; w++) begin
            cyc();
            done_i = (w == 2);
            sample();
            n_checks++;
            if (bus.rsp_valid !== 4'b0010 || bus.rsp_cycles !== 32'd3 || bus.rsp_err !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold w=%0d valid=%b cyc=%0d err=%b want 0010 3 0",
                                   w, bus.rsp_valid, bus.rsp_cycles, bus.rsp_err);
            end
        end
        cyc();
        done_i = 1'b0;
        bus.rsp_ready = 4'b0010;
        cyc();
        bus.rsp_ready = '0;
        sample();
        n_checks++;
        if (busy_o !== 1'b0 || bus.rsp_valid !== '0) begin
            n_fail++; $display("FAIL bp_idle busy=%b valid=%b want 0 0000", busy_o, bus.rsp_valid);
        end
        cyc();
        sample();
        n_checks++;
        if (busy_o !== 1'b0 || bus.rsp_valid !== '0 || start_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_second busy=%b valid=%b start=%b want 0 0000 0",
                               busy_o, bus.rsp_valid, start_o);
        end
    endtask

    task automatic test_reset_mid_job();
        cyc();
        set_job(2'd2, '{m_size: 16'd3, k_size: 16'd3, n_size: 16'd3});
        bus.req_valid = 4'b0100;
        sample();
        n_checks++;
        if (bus.req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL rst_grant got %b want 0100", bus.req_ready);
        end
        cyc();
        bus.req_valid = '0;
        repeat (2) cyc();
        rst_ni = 1'b0;
        #2;
        n_checks++;
        if ({start_o, busy_o, owner_o, m_size_o, k_size_o, n_size_o, bus.rsp_valid,
             bus.rsp_err, bus.rsp_cycles, bus.req_ready} !== '0) begin
            n_fail++; $display("FAIL rst_outputs busy=%b owner=%0d m=%0d valid=%b cyc=%0d want all 0",
                               busy_o, owner_o, m_size_o, bus.rsp_valid, bus.rsp_cycles);
        end
        cyc();
        rst_ni = 1'b1;
        bus.req_valid = '1;
        sample();
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rst_first_grant got %b want 0001", bus.req_ready);
        end
        exp_q.push_back('{owner: 2'd0, err: 1'b0, cycles: 32'd1});
        cyc();
        bus.req_valid = '0;
        cyc();
        done_i = 1'b1;
        cyc();
        done_i = 1'b0;
        sample();
        n_checks++;
        if (exp_q.size() == 0 || bus.rsp_valid !== 4'b0001) begin
            n_fail++; $display("FAIL rst_rsp_valid got %b queue=%0d want 0001 nonempty",
                               bus.rsp_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (bus.rsp_cycles !== e.cycles || owner_o !== e.owner) begin
                n_fail++; $display("FAIL rst_rsp cyc=%0d owner=%0d want %0d %0d",
                                   bus.rsp_cycles, owner_o, e.cycles, e.owner);
            end
        end
        bus.rsp_ready = 4'b0001;
        cyc();
        bus.rsp_ready = '0;
        sample();
        n_checks++;
        if (busy_o !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL rst_end busy=%b queue=%0d want 0 0", busy_o, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_zero_size();
        test_fast_done();
        test_backpressure();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got no end want end of test");
        $fatal(1, "timeout");
    end

endmodule
